// File: rtl/vmem_pkg.sv
// Shared definitions for the level-0 map stage and its sequencer:
// op codes, sequencer states, VMEM1 entry bit positions and fault decode.
package vmem_pkg;

   localparam int L0_AW          = 11;
   localparam int L0_DW          = 5;
   localparam int PPN_W          = 14;
   localparam int VMO_W          = 24;
   localparam int VMO_ACCESS_BIT = 23;
   localparam int VMO_WRITE_BIT  = 22;

   typedef enum logic [1:0] {
      VMOP_RD = 2'd0,
      VMOP_WR = 2'd1,
      VMOP_W0 = 2'd2,
      VMOP_W1 = 2'd3
   } vmop_e;

   typedef enum logic [2:0] {
      IDLE,
      L0RD,
      L1RD,
      CHK,
      WR0,
      WR1
   } vmstate_e;

   typedef struct packed {
      logic fault_access;
      logic fault_write;
   } vm_fault_t;

   // An entry without the access bit faults any translate; a write
   // translate additionally faults when the entry is not writable.
   function automatic vm_fault_t calc_faults(input vmop_e op, input logic [VMO_W-1:0] vmo);
      vm_fault_t f;
      f.fault_access = ~vmo[VMO_ACCESS_BIT];
      f.fault_write  = (op == VMOP_WR) & vmo[VMO_ACCESS_BIT] & ~vmo[VMO_WRITE_BIT];
      return f;
   endfunction

endpackage

// File: rtl/vmem0_ram.sv
// Level-0 map storage: single-port synchronous RAM with separate read and
// write enables and a registered read port, shaped so it can be swapped
// for a vendor block RAM. Contents are never reset; only the output
// register clears so the downstream vmap starts at a known value.
module vmem0_ram #(
   parameter int AW = 11,
   parameter int DW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Array write port; the array keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered read port; holds its last value when not reading.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/vmem0_map_seq.sv
// Level-0 virtual memory map stage and access sequencer. Looks up the
// level-0 entry for a virtual address, drives the VMEM1 level-1 map with a
// stable address and strobe, and turns the returned entry into a physical
// page number plus access/write faults. Also sequences map writes for
// both levels.
module vmem0_map_seq
   import vmem_pkg::*;
#(
   parameter int L0_AW = vmem_pkg::L0_AW,
   parameter int L0_DW = vmem_pkg::L0_DW,
   parameter int PPN_W = vmem_pkg::PPN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [15:0]      mapi,
   input  logic [31:0]      vma,
   output logic [L0_DW-1:0] vmap,
   output logic             vm1rp,
   output logic             vm1wp,
   output logic [4:0]       vm1_adr_lo,
   output logic [23:0]      vm1_wdata,
   input  logic [23:0]      vmo,
   output logic             rsp_valid,
   output logic [PPN_W-1:0] ppn,
   output logic             fault_access,
   output logic             fault_write
);

   vmstate_e         state;
   vmstate_e         state_nx;
   vmop_e            op_q;
   logic [15:0]      mapi_q;
   logic [L0_DW-1:0] l0_data_q;
   logic [23:0]      l1_data_q;
   logic             accept;
   logic             ram_we;
   logic             ram_re;
   logic [L0_AW-1:0] ram_addr;
   vm_fault_t        chk_faults;
   logic [PPN_W-1:0] ppn_q;
   logic             fault_access_q;
   logic             fault_write_q;
   logic             unused_vmo_bits;

   // The level-0 index is the top of the latched address; the low five
   // bits go straight to VMEM1 and stay put for the whole transaction.
   assign ram_addr   = mapi_q[15 -: L0_AW];
   assign vm1_adr_lo = mapi_q[4:0];
   assign vm1_wdata  = l1_data_q;
   assign accept     = req_valid & req_ready;

   // Entry bits between the page number and the permission bits carry
   // nothing for this stage.
   assign unused_vmo_bits = ^vmo[VMO_WRITE_BIT-1:PPN_W];

   vmem0_ram #(
      .AW (L0_AW),
      .DW (L0_DW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (l0_data_q),
      .rdata (vmap)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Capture the request on accept so the RAM and VMEM1 see stable inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q      <= VMOP_RD;
         mapi_q    <= '0;
         l0_data_q <= '0;
         l1_data_q <= '0;
      end else if (accept) begin
         op_q      <= vmop_e'(req_op);
         mapi_q    <= mapi;
         l0_data_q <= vma[31 -: L0_DW];
         l1_data_q <= vma[23:0];
      end
   end

   // Next state and per-state strobes. Ready is withheld while reset is
   // asserted so nothing is offered to the requester until release.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      vm1rp     = 1'b0;
      vm1wp     = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = reset;
            if (req_valid && reset) begin
               state_nx = (req_op == VMOP_W0) ? WR0 : L0RD;
            end
         end
         L0RD: begin
            ram_re   = 1'b1;
            state_nx = (op_q == VMOP_W1) ? WR1 : L1RD;
         end
         L1RD: begin
            vm1rp    = 1'b1;
            state_nx = CHK;
         end
         CHK: begin
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         WR0: begin
            ram_we    = 1'b1;
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         WR1: begin
            vm1wp     = 1'b1;
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Completion results: a translate reports the live VMEM1 entry during
   // its response cycle, map writes report no faults and keep the old page
   // number; outside a response the last reported values are held.
   always_comb begin
      chk_faults   = calc_faults(op_q, vmo);
      ppn          = ppn_q;
      fault_access = fault_access_q;
      fault_write  = fault_write_q;
      if (state == CHK) begin
         ppn          = vmo[PPN_W-1:0];
         fault_access = chk_faults.fault_access;
         fault_write  = chk_faults.fault_write;
      end else if (state == WR0 || state == WR1) begin
         fault_access = 1'b0;
         fault_write  = 1'b0;
      end
   end

   // Hold completion results until the next response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ppn_q          <= '0;
         fault_access_q <= 1'b0;
         fault_write_q  <= 1'b0;
      end else if (rsp_valid) begin
         ppn_q          <= ppn;
         fault_access_q <= fault_access;
         fault_write_q  <= fault_write;
      end
   end

endmodule

// File: tb/tb_vmem0_map_seq.sv
// Self-checking bench for vmem0_map_seq with a small VMEM1 read model, a
// level-0 map model and a scoreboard of expected responses.
module tb_vmem0_map_seq;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] mapi;
   logic [31:0] vma;
   logic [4:0]  vmap;
   logic        vm1rp;
   logic        vm1wp;
   logic [4:0]  vm1_adr_lo;
   logic [23:0] vm1_wdata;
   logic [23:0] vmo;
   logic        rsp_valid;
   logic [13:0] ppn;
   logic        fault_access;
   logic        fault_write;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  l0;
      logic [4:0]  adr_lo;
      logic [23:0] wdata;
      logic [13:0] ppn;
      logic        fa;
      logic        fw;
      int          accept_cyc;
   } exp_item_t;

   exp_item_t   sb_queue[$];
   logic [4:0]  l0_model [0:2047];
   logic [13:0] last_ppn;
   logic [23:0] vmo_resp;
   int          cycle;
   int          checks;
   int          errors;

   vmem0_map_seq dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .mapi         (mapi),
      .vma          (vma),
      .vmap         (vmap),
      .vm1rp        (vm1rp),
      .vm1wp        (vm1wp),
      .vm1_adr_lo   (vm1_adr_lo),
      .vm1_wdata    (vm1_wdata),
      .vmo          (vmo),
      .rsp_valid    (rsp_valid),
      .ppn          (ppn),
      .fault_access (fault_access),
      .fault_write  (fault_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index; a request seen ready between edges belongs to that index.
   always @(posedge clk) cycle <= cycle + 1;

   // VMEM1 model: registered read data one cycle after the read strobe.
   always @(posedge clk) begin
      if (vm1rp) vmo <= vmo_resp;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cycle);
      end
   endtask

   // Record what the DUT must produce for a request accepted this cycle.
   task automatic pushExpected(input logic [1:0] op, input logic [15:0] m, input logic [31:0] v,
                               input logic [23:0] vr);
      exp_item_t it;
      logic [10:0] idx;
      idx          = m[15:5];
      it.op        = op;
      it.adr_lo    = m[4:0];
      it.wdata     = v[23:0];
      it.accept_cyc = cycle;
      it.l0        = l0_model[idx];
      it.ppn       = last_ppn;
      it.fa        = 1'b0;
      it.fw        = 1'b0;
      if (op < 2) begin
         it.ppn   = vr[13:0];
         it.fa    = ~vr[23];
         it.fw    = (op == 2'd1) & vr[23] & ~vr[22];
         last_ppn = vr[13:0];
      end else if (op == 2'd2) begin
         l0_model[idx] = v[31:27];
         it.l0         = v[31:27];
      end
      sb_queue.push_back(it);
   endtask

   // Issue one request, then wait for its response to drain.
   task automatic applyStimulus(input logic [1:0] op, input logic [15:0] m, input logic [31:0] v,
                                input logic [23:0] vr);
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!req_ready && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         checkOutput("readyTimeout", {31'b0, req_ready}, 32'd1);
      end else begin
         vmo_resp  = vr;
         req_op    = op;
         mapi      = m;
         vma       = v;
         req_valid = 1'b1;
         pushExpected(op, m, v, vr);
         @(negedge clk); #1;
         req_valid = 1'b0;
         n = 0;
         while (sb_queue.size() != 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
         end
         if (sb_queue.size() != 0) checkOutput("drainTimeout", sb_queue.size(), 32'd0);
      end
   endtask

   // Strobe, address and response monitor against the scoreboard head.
   always @(negedge clk) begin : monitor
      logic exp_rp;
      logic exp_wp;
      int   exp_lat;
      exp_item_t it;
      if (reset === 1'b1) begin
         exp_rp = 1'b0;
         exp_wp = 1'b0;
         if (sb_queue.size() > 0 && cycle == sb_queue[0].accept_cyc + 2) begin
            exp_rp = (sb_queue[0].op < 2);
            exp_wp = (sb_queue[0].op == 2'd3);
         end
         checkOutput("vm1rp", {31'b0, vm1rp}, {31'b0, exp_rp});
         checkOutput("vm1wp", {31'b0, vm1wp}, {31'b0, exp_wp});
         if (exp_rp || exp_wp) begin
            checkOutput("vmapAtStrobe", {27'b0, vmap}, {27'b0, sb_queue[0].l0});
            checkOutput("adrLoAtStrobe", {27'b0, vm1_adr_lo}, {27'b0, sb_queue[0].adr_lo});
         end
         if (exp_wp) checkOutput("vm1Wdata", {8'b0, vm1_wdata}, {8'b0, sb_queue[0].wdata});
         if (rsp_valid) begin
            if (sb_queue.size() == 0) begin
               checkOutput("unexpectedRsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
               it = sb_queue.pop_front();
               exp_lat = (it.op < 2) ? 3 : ((it.op == 2'd2) ? 1 : 2);
               checkOutput("rspLatency", cycle - it.accept_cyc, exp_lat);
               checkOutput("ppn", {18'b0, ppn}, {18'b0, it.ppn});
               checkOutput("faultAccess", {31'b0, fault_access}, {31'b0, it.fa});
               checkOutput("faultWrite", {31'b0, fault_write}, {31'b0, it.fw});
            end
         end else if (sb_queue.size() > 0 && cycle > sb_queue[0].accept_cyc + 3) begin
            checkOutput("rspMissing", {31'b0, rsp_valid}, 32'd1);
            void'(sb_queue.pop_front());
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int accepts;
      int ready_low;
      logic [15:0] bases [2];
      logic [15:0] m;
      logic [1:0]  op;
      checks    = 0;
      errors    = 0;
      cycle     = 0;
      last_ppn  = '0;
      vmo_resp  = '0;
      vmo       = '0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      mapi      = '0;
      vma       = '0;
      reset     = 1'b1;
      #1 reset  = 1'b0;

      // Reset values while reset is held low.
      @(negedge clk);
      checkOutput("rstReady", {31'b0, req_ready}, 32'd0);
      checkOutput("rstVm1rp", {31'b0, vm1rp}, 32'd0);
      checkOutput("rstVm1wp", {31'b0, vm1wp}, 32'd0);
      checkOutput("rstRsp", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rstVmap", {27'b0, vmap}, 32'd0);
      checkOutput("rstPpn", {18'b0, ppn}, 32'd0);
      checkOutput("rstFaults", {30'b0, fault_access, fault_write}, 32'd0);
      checkOutput("rstAdrLo", {27'b0, vm1_adr_lo}, 32'd0);
      checkOutput("rstWdata", {8'b0, vm1_wdata}, 32'd0);
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("readyAfterRst", {31'b0, req_ready}, 32'd1);

      // Level-0 write then translates of the same entry, covering fault cases.
      applyStimulus(2'd2, 16'hA500, {5'h13, 27'h0}, 24'h0);
      applyStimulus(2'd0, 16'hA512, 32'h0, 24'hC01234);
      applyStimulus(2'd0, 16'hA512, 32'h0, 24'h401234);
      applyStimulus(2'd1, 16'hA500, 32'h0, 24'h800042);
      applyStimulus(2'd1, 16'hA503, 32'h0, 24'hC00099);
      applyStimulus(2'd1, 16'hA503, 32'h0, 24'h000111);

      // Level-1 write through a freshly written level-0 entry.
      applyStimulus(2'd2, 16'h3C40, {5'h0A, 27'h0}, 24'h0);
      applyStimulus(2'd3, 16'h3C41, {8'hFF, 24'hC00777}, 24'h0);

      // Request held high across a translate: one accept, ready low 3 cycles.
      accepts   = 0;
      ready_low = 0;
      vmo_resp  = 24'hC00123;
      req_op    = 2'd0;
      mapi      = 16'h3C45;
      vma       = 32'h0;
      @(negedge clk); #1;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk); #1;
         end
         if (req_ready) begin
            accepts++;
            pushExpected(req_op, mapi, vma, vmo_resp);
         end else begin
            ready_low++;
         end
      end
      req_valid = 1'b0;
      checkOutput("heldAccepts", accepts, 32'd1);
      checkOutput("heldReadyLow", ready_low, 32'd3);
      for (int i = 0; i < 4; i++) @(negedge clk);

      // Random mix over the two populated level-0 entries.
      bases[0] = 16'hA500;
      bases[1] = 16'h3C40;
      for (int i = 0; i < 12; i++) begin
         m  = bases[$urandom_range(0, 1)] | 16'($urandom_range(0, 31));
         op = 2'($urandom_range(0, 3));
         applyStimulus(op, m, $urandom, 24'($urandom));
      end

      // Reset in the middle of a VMEM1 read aborts the transaction.
      @(negedge clk); #1;
      vmo_resp  = 24'hC00555;
      req_op    = 2'd0;
      mapi      = 16'hA501;
      vma       = 32'h0;
      req_valid = 1'b1;
      pushExpected(req_op, mapi, vma, vmo_resp);
      @(negedge clk); #1;
      req_valid = 1'b0;
      for (int n = 0; n < 10 && !vm1rp; n++) begin
         @(negedge clk); #1;
      end
      checkOutput("midRstStrobeSeen", {31'b0, vm1rp}, 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("midRstVm1rp", {31'b0, vm1rp}, 32'd0);
      checkOutput("midRstRsp", {31'b0, rsp_valid}, 32'd0);
      sb_queue.delete();
      last_ppn = '0;
      @(negedge clk);
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("readyAfterMidRst", {31'b0, req_ready}, 32'd1);
      checkOutput("noRspAfterMidRst", {31'b0, rsp_valid}, 32'd0);
      applyStimulus(2'd0, 16'hA501, 32'h0, 24'hC00321);
      applyStimulus(2'd3, 16'h3C42, 32'h0, 24'h0);

      for (int i = 0; i < 3; i++) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vmem0_map_seq.md
Name: vmem0_map_seq

Overview:
- Level-0 virtual memory map stage plus its access sequencer. It sits directly upstream of the VMEM1 level-1 map RAM.
- Holds the 2048x5 level-0 map and looks it up with mapi[23:13] to produce vmap[4:0].
- Drives vm1rp/vm1wp into VMEM1 and consumes the 24-bit vmo that VMEM1 returns. From vmo it produces the physical page number and the access/write fault flags.
- Also sequences map writes for both levels.

Parameters:
- L0_AW, 11, level-0 map address width (indexed by mapi[23:13]).
- L0_DW, 5, level-0 map entry width (the vmap width).
- PPN_W, 14, physical page number width, taken from vmo[13:0].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_op  in  2  0=translate-read, 1=translate-write, 2=write level-0, 3=write level-1.
- mapi  in  16  [23:8] virtual address bits; captured on accept.
- vma  in  32  write data; [31:27] is the level-0 entry, [23:0] the level-1 entry; captured on accept.
- vmap  out  5  level-0 entry fed to VMEM1; registered.
- vm1rp  out  1  VMEM1 read strobe.
- vm1wp  out  1  VMEM1 write strobe.
- vm1_adr_lo  out  5  latched mapi[12:8], fed to VMEM1 so its address stays stable.
- vm1_wdata  out  24  latched vma[23:0].
- vmo  in  24  VMEM1 registered read data; valid one cycle after vm1rp.
- rsp_valid  out  1  one-cycle completion pulse.
- ppn  out  14  vmo[13:0], captured at completion.
- fault_access  out  1  valid with rsp_valid.
- fault_write  out  1  valid with rsp_valid.

Behaviour:
- Reset values (asynchronous, while reset low):
  - state=IDLE.
  - vmap, ppn, vm1_adr_lo, vm1_wdata, latched op and latched data all 0.
  - vm1rp, vm1wp, rsp_valid, fault_access, fault_write all 0.
  - req_ready goes to 1 once reset is released.
  - Level-0 RAM contents are not reset and are retained across reset.
- Level-0 RAM: synchronous read, synchronous write, 1-cycle read latency, single port.
- States and transitions:
  - IDLE:
    - on accept, latch op, mapi and vma.
    - op 0/1/3 go to L0RD; op 2 goes to WR0.
  - L0RD: read RAM at mapi_q[23:13]; vmap loads the read data at the end of the cycle.
    - op 0/1 go to L1RD; op 3 goes to WR1.
  - L1RD: vm1rp=1 for exactly one cycle; vmap and vm1_adr_lo held stable. Goes to CHK.
  - CHK: sample vmo, set rsp_valid=1.
    - ppn=vmo[13:0].
    - fault_access=~vmo[23].
    - fault_write=(op==1)&vmo[23]&~vmo[22].
    - Goes to IDLE.
  - WR0: write RAM[mapi_q[23:13]] <= vma_q[31:27]; rsp_valid=1 with both faults 0. Goes to IDLE.
  - WR1: vm1wp=1 for exactly one cycle with vmap, vm1_adr_lo and vm1_wdata stable; rsp_valid=1, faults 0. Goes to IDLE.
- Latency, counted from the accept edge:
  - translate: rsp_valid 3 cycles after accept.
  - write level-0: 1 cycle after accept.
  - write level-1: 2 cycles after accept.
- Throughput: no new accept until the cycle after rsp_valid, when state is back in IDLE. Back-to-back requests therefore see one idle-accept cycle.
- Read-after-write: a level-0 write followed by a translate of the same entry must return the new value; the RAM write lands before L0RD.
- Strobe rules:
  - vm1rp and vm1wp are never high together.
  - Neither strobe is high outside L1RD or WR1.
- req_valid while req_ready=0 is ignored, with no queuing.
- ppn and the fault flags hold their last value until the next completion.
  - WR0/WR1 completions clear the faults but leave ppn unchanged.
- Reset mid-operation: abort immediately; strobes drop asynchronously; no rsp_valid is produced. A pending RAM write not yet clocked is lost.

Decomposition:
- Shared package vmem_pkg:
  - op codes VMOP_RD=2'd0, VMOP_WR=2'd1, VMOP_W0=2'd2, VMOP_W1=2'd3.
  - state enum {IDLE, L0RD, L1RD, CHK, WR0, WR1}.
  - VMO_ACCESS_BIT=23, VMO_WRITE_BIT=22.
  - PPN_W.
- One sub-module: vmem0_ram (2048x5 synchronous single-port RAM, write-enable plus read-enable) so it can be retargeted to vendor block RAM.
- The FSM and fault logic stay in the top level.

Test Plan:
- Reset low mid-L1RD (vm1rp=1) -> vm1rp drops asynchronously; after release req_ready=1, no rsp_valid, and a translate of a previously written entry still returns the old data.
- W0 at mapi=16'hA5xx, vma[31:27]=5'h13; then RD at same mapi with VMEM1 model returning vmo=24'hC01234 -> vmap=5'h13 during vm1rp; rsp_valid 3 cycles after accept; ppn=14'h1234, faults 0.
- RD where the model returns vmo=24'h401234 -> fault_access=1, fault_write=0.
- WR op where the model returns vmo=24'h800042 -> fault_access=0, fault_write=1, ppn=14'h0042.
- W1 with vma[23:0]=24'hC00777 -> vm1wp high exactly one cycle, 2 cycles after accept, with vm1_wdata=24'hC00777 and vmap equal to the level-0 entry; vm1rp stays 0 throughout.
- req_valid held high continuously across an RD -> exactly one accept per transaction; req_ready=0 for 3 cycles; vm1rp and vm1wp never overlap.
